// File: rtl/cdr_tx_pkg.sv
// Shared types and constants for the CDR transmit serializer and its PRBS7 source.
package cdr_tx_pkg;

    typedef enum logic [1:0] {
        S_TRAIN,
        S_SYNC,
        S_DATA,
        S_IDLE
    } state_t;

    localparam logic [7:0] SYNC_WORD = 8'hD5;
    localparam int         SYNC_LEN  = 8;

    // x^7 + x^6 + 1: feedback taps, the output is taken from the high tap.
    localparam int PRBS7_TAP_HI = 6;
    localparam int PRBS7_TAP_LO = 5;

    function automatic logic [6:0] prbs7_next(input logic [6:0] lfsr);
        return {lfsr[5:0], lfsr[PRBS7_TAP_HI] ^ lfsr[PRBS7_TAP_LO]};
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cdr_tx_serializer_prbs7.sv
// Fibonacci PRBS7 source that steps only when asked; also intended for a receive-side checker.
module prbs7_gen
    import cdr_tx_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic refclk,
    input  logic rst_n,
    input  logic adv,
    output logic prbs_out
);

    logic [6:0] lfsr_q;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (adv) begin
            lfsr_q <= prbs7_next(lfsr_q);
        end
    end

    assign prbs_out = lfsr_q[PRBS7_TAP_HI];

endmodule

// File: rtl/cdr_tx_serializer.sv
// Serial transmitter for the CDR receive path: training preamble, sync-framed MSB-first bursts,
// and alternating or PRBS7 idle fill, one bit per refclk.
module cdr_tx_serializer
    import cdr_tx_pkg::*;
#(
    parameter int         WORD_W       = 8,
    parameter int         PREAMBLE_LEN = 16,
    parameter logic [6:0] PRBS_SEED    = 7'h7F
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              prbs_en,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              d,
    output logic              sof,
    output logic              busy
);

    localparam int CNT_W = $clog2(max3(PREAMBLE_LEN, WORD_W, SYNC_LEN));
    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(WORD_W - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              hold_v_q, hold_v_d;
    logic              alt_q, alt_d;
    logic              d_d, sof_d, busy_d;
    logic [2:0]        sync_idx;
    logic              accept;
    logic              prbs_adv;
    logic              prbs_bit;

    assign accept   = tx_valid && !hold_v_q;
    assign tx_ready = !hold_v_q;
    assign prbs_adv = (state_q == S_IDLE) && prbs_en;

    prbs7_gen #(
        .SEED(PRBS_SEED)
    ) u_prbs (
        .refclk  (refclk),
        .rst_n   (rst_n),
        .adv     (prbs_adv),
        .prbs_out(prbs_bit)
    );

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 1'b1;
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
        shift_d   = shift_q;
        alt_d     = alt_q;
        d_d       = 1'b0;
        sof_d     = 1'b0;
        busy_d    = 1'b0;
        sync_idx  = 3'd7 - bit_cnt_q[2:0];

        if (accept) begin
            hold_d   = tx_data;
            hold_v_d = 1'b1;
        end

        unique case (state_q)
            S_TRAIN: begin
                d_d   = alt_q;
                alt_d = !alt_q;
                if (bit_cnt_q == TRAIN_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = hold_v_q ? S_SYNC : S_IDLE;
                end
            end
            S_SYNC: begin
                d_d    = SYNC_WORD[sync_idx];
                sof_d  = (bit_cnt_q == '0);
                busy_d = 1'b1;
                if (bit_cnt_q == SYNC_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                busy_d = 1'b1;
                // The shifter loads on the edge that emits the MSB, freeing the hold slot for the next word.
                if (bit_cnt_q == '0) begin
                    d_d      = hold_q[WORD_W-1];
                    shift_d  = {hold_q[WORD_W-2:0], 1'b0};
                    hold_v_d = 1'b0;
                end else begin
                    d_d     = shift_q[WORD_W-1];
                    shift_d = {shift_q[WORD_W-2:0], 1'b0};
                end
                if (bit_cnt_q == DATA_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = hold_v_q ? S_DATA : S_IDLE;
                end
            end
            S_IDLE: begin
                bit_cnt_d = '0;
                if (prbs_en) begin
                    d_d = prbs_bit;
                end else begin
                    d_d   = alt_q;
                    alt_d = !alt_q;
                end
                if (hold_v_q || accept) begin
                    state_d = S_SYNC;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_TRAIN;
            bit_cnt_q <= '0;
            // NOTE: the data registers are reset too, so nothing of an interrupted word survives a reset.
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            shift_q   <= '0;
            alt_q     <= 1'b1;
            d         <= 1'b0;
            sof       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
            shift_q   <= shift_d;
            alt_q     <= alt_d;
            d         <= d_d;
            sof       <= sof_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_cdr_tx_serializer.sv
// Directed self-checking bench for cdr_tx_serializer: preamble, framing, streaming, PRBS idle and reset.
module tb_cdr_tx_serializer;

    localparam int         WORD_W       = 8;
    localparam int         PREAMBLE_LEN = 16;
    localparam logic [7:0] SYNC_W       = 8'hD5;

    logic              refclk   = 1'b0;
    logic              rst_n    = 1'b0;
    logic              prbs_en  = 1'b0;
    logic              tx_valid = 1'b0;
    logic [WORD_W-1:0] tx_data  = '0;
    logic              tx_ready;
    logic              d;
    logic              sof;
    logic              busy;

    int   checks  = 0;
    int   errors  = 0;
    logic exp_alt = 1'b1;

    cdr_tx_serializer #(
        .WORD_W      (WORD_W),
        .PREAMBLE_LEN(PREAMBLE_LEN),
        .PRBS_SEED   (7'h7F)
    ) dut (
        .refclk  (refclk),
        .rst_n   (rst_n),
        .prbs_en (prbs_en),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .d       (d),
        .sof     (sof),
        .busy    (busy)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        prbs_en  = 1'b0;
        tx_valid = 1'b0;
        #23;
        checks++;
        if ({d, sof, busy, tx_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_outputs: got d/sof/busy/rdy=%b want 0001", {d, sof, busy, tx_ready});
        end
        @(negedge refclk);
        rst_n   = 1'b1;
        exp_alt = 1'b1;
    endtask

    task automatic test_preamble();
        for (int i = 0; i < PREAMBLE_LEN + 8; i++) begin
            tick();
            checks++;
            if (d !== exp_alt) begin
                errors++;
                $display("FAIL preamble_d[%0d]: got %b want %b", i, d, exp_alt);
            end
            exp_alt = !exp_alt;
            checks++;
            if ({sof, busy, tx_ready} !== 3'b001) begin
                errors++;
                $display("FAIL preamble_ctl[%0d]: got sof/busy/rdy=%b want 001", i, {sof, busy, tx_ready});
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w        = 8'hA5;
        tx_data  = w;
        tx_valid = 1'b1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_pre: got %b want 1", tx_ready);
        end
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        checks++;
        if ({d, busy, tx_ready} !== {exp_alt, 2'b00}) begin
            errors++;
            $display("FAIL single_accept: got d/busy/rdy=%b want %b00", {d, busy, tx_ready}, exp_alt);
        end
        exp_alt = !exp_alt;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({d, sof, busy, tx_ready} !== {SYNC_W[7-k], (k == 0), 2'b10}) begin
                errors++;
                $display("FAIL single_sync[%0d]: got d/sof/busy/rdy=%b want %b", k,
                         {d, sof, busy, tx_ready}, {SYNC_W[7-k], (k == 0), 2'b10});
            end
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({d, sof, busy, tx_ready} !== {w[7-k], 3'b011}) begin
                errors++;
                $display("FAIL single_data[%0d]: got d/sof/busy/rdy=%b want %b", k,
                         {d, sof, busy, tx_ready}, {w[7-k], 3'b011});
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({d, sof, busy} !== {exp_alt, 2'b00}) begin
                errors++;
                $display("FAIL single_idle[%0d]: got d/sof/busy=%b want %b00", k, {d, sof, busy}, exp_alt);
            end
            exp_alt = !exp_alt;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic       d_log [40];
        logic       sof_log [40];
        logic       busy_log [40];
        int         acc_at [3];
        int         n_acc;
        int         idx;
        logic       rdy;
        logic       exp_d;
        words[0] = 8'hFF;
        words[1] = 8'h00;
        words[2] = 8'h3C;
        acc_at   = '{-1, -1, -1};
        n_acc    = 0;
        tx_data  = words[0];
        tx_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            rdy = tx_ready;
            tick();
            if (rdy && tx_valid) begin
                if (n_acc < 3) acc_at[n_acc] = c;
                n_acc++;
                if (n_acc < 3) begin
                    tx_data = words[n_acc];
                end else begin
                    tx_valid = 1'b0;
                    tx_data  = 8'h00;
                end
            end
            d_log[c]    = d;
            sof_log[c]  = sof;
            busy_log[c] = busy;
        end
        tx_valid = 1'b0;
        checks++;
        if (n_acc !== 3) begin
            errors++;
            $display("FAIL b2b_accept_count: got %0d want 3", n_acc);
        end
        checks++;
        if (acc_at[0] !== 0 || acc_at[1] !== 10 || acc_at[2] !== 18) begin
            errors++;
            $display("FAIL b2b_accept_cycles: got %0d,%0d,%0d want 0,10,18", acc_at[0], acc_at[1], acc_at[2]);
        end
        for (int c = 0; c < 40; c++) begin
            if (c == 0 || c > 32) begin
                exp_d   = exp_alt;
                exp_alt = !exp_alt;
            end else if (c <= 8) begin
                exp_d = SYNC_W[8-c];
            end else begin
                idx   = c - 9;
                exp_d = words[idx / 8][7 - (idx % 8)];
            end
            checks++;
            if ({d_log[c], sof_log[c], busy_log[c]} !== {exp_d, (c == 1), (c >= 1 && c <= 32)}) begin
                errors++;
                $display("FAIL b2b_stream[%0d]: got d/sof/busy=%b want %b", c,
                         {d_log[c], sof_log[c], busy_log[c]}, {exp_d, (c == 1), (c >= 1 && c <= 32)});
            end
        end
    endtask

    task automatic test_prbs_idle();
        logic       bits [254];
        logic [6:0] m;
        logic [7:0] head;
        int         ones;
        m       = 7'h7F;
        head    = 8'b1111_1110;
        ones    = 0;
        prbs_en = 1'b1;
        for (int i = 0; i < 254; i++) begin
            tick();
            bits[i] = d;
            checks++;
            if ({d, busy} !== {m[6], 1'b0}) begin
                errors++;
                $display("FAIL prbs_model[%0d]: got d/busy=%b want %b0", i, {d, busy}, m[6]);
            end
            m = {m[5:0], m[6] ^ m[5]};
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bits[i] !== head[7-i]) begin
                errors++;
                $display("FAIL prbs_head[%0d]: got %b want %b", i, bits[i], head[7-i]);
            end
        end
        for (int i = 0; i < 127; i++) begin
            checks++;
            if (bits[i + 127] !== bits[i]) begin
                errors++;
                $display("FAIL prbs_period[%0d]: got %b want %b", i, bits[i + 127], bits[i]);
            end
            if (bits[i] === 1'b1) ones++;
        end
        checks++;
        if (ones !== 64) begin
            errors++;
            $display("FAIL prbs_ones: got %0d want 64", ones);
        end
        prbs_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (d !== exp_alt) begin
                errors++;
                $display("FAIL prbs_alt_resume[%0d]: got %b want %b", k, d, exp_alt);
            end
            exp_alt = !exp_alt;
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] w;
        w        = 8'hC3;
        tx_data  = w;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hFF;
        exp_alt = !exp_alt;
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({d, busy} !== {w[7-k], 1'b1}) begin
                errors++;
                $display("FAIL midrst_data[%0d]: got d/busy=%b want %b1", k, {d, busy}, w[7-k]);
            end
        end
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_held: got rdy=%b want 0", tx_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({d, sof, busy, tx_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_async: got d/sof/busy/rdy=%b want 0001", {d, sof, busy, tx_ready});
        end
        @(negedge refclk);
        rst_n   = 1'b1;
        exp_alt = 1'b1;
        for (int i = 0; i < PREAMBLE_LEN + 8; i++) begin
            tick();
            checks++;
            if ({d, sof, busy, tx_ready} !== {exp_alt, 3'b001}) begin
                errors++;
                $display("FAIL midrst_restart[%0d]: got d/sof/busy/rdy=%b want %b001", i,
                         {d, sof, busy, tx_ready}, exp_alt);
            end
            exp_alt = !exp_alt;
        end
    endtask

    task automatic test_word_in_preamble();
        logic [7:0] w;
        w     = 8'h96;
        rst_n = 1'b0;
        #12;
        @(negedge refclk);
        rst_n   = 1'b1;
        exp_alt = 1'b1;
        for (int e = 1; e <= PREAMBLE_LEN; e++) begin
            if (e == 3) begin
                tx_data  = w;
                tx_valid = 1'b1;
                checks++;
                if (tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL pre_word_ready: got %b want 1", tx_ready);
                end
            end
            tick();
            if (e == 3) begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
            checks++;
            if ({d, sof, busy, tx_ready} !== {exp_alt, 2'b00, (e < 3)}) begin
                errors++;
                $display("FAIL pre_word_train[%0d]: got d/sof/busy/rdy=%b want %b", e,
                         {d, sof, busy, tx_ready}, {exp_alt, 2'b00, (e < 3)});
            end
            exp_alt = !exp_alt;
        end
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++;
            if (k < 8) begin
                if ({d, sof, busy, tx_ready} !== {SYNC_W[7-k], (k == 0), 2'b10}) begin
                    errors++;
                    $display("FAIL pre_word_sync[%0d]: got d/sof/busy/rdy=%b want %b", k,
                             {d, sof, busy, tx_ready}, {SYNC_W[7-k], (k == 0), 2'b10});
                end
            end else begin
                if ({d, sof, busy, tx_ready} !== {w[15-k], 3'b011}) begin
                    errors++;
                    $display("FAIL pre_word_data[%0d]: got d/sof/busy/rdy=%b want %b", k - 8,
                             {d, sof, busy, tx_ready}, {w[15-k], 3'b011});
                end
            end
        end
        tick();
        checks++;
        if ({d, busy} !== {exp_alt, 1'b0}) begin
            errors++;
            $display("FAIL pre_word_idle: got d/busy=%b want %b0", {d, busy}, exp_alt);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_preamble();
        test_single_word();
        test_back_to_back();
        test_prbs_idle();
        test_reset_mid_word();
        test_word_in_preamble();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
